// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA raster
// generator. Used by vga_axis_counter and vga_timing_gen.
package vga_timing_pkg;

  // Width of the x/y coordinate buses and of the frame counter.
  localparam int COORD_W = 10;

  // Phase of one raster axis within a line (horizontal) or frame (vertical).
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_phase_t;

  // Default 640x480@60 timing (25.175 MHz pixel rate).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Pin level for a sync signal: the polarity value while asserted,
  // its complement otherwise.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter plus a four-phase FSM
// (ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE). Instantiated once for the
// horizontal axis (stepped every pixel) and once for the vertical axis
// (stepped on horizontal wrap). The phase output doubles as the FSM state
// visible for debug.
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic [COORD_W-1:0] len_active,
  input  logic [COORD_W-1:0] len_front,
  input  logic [COORD_W-1:0] len_sync,
  input  logic [COORD_W-1:0] len_back,
  output logic [COORD_W-1:0] count,
  output axis_phase_t        phase,
  output logic               wrap
);

  logic [COORD_W-1:0] start_front;
  logic [COORD_W-1:0] start_sync;
  logic [COORD_W-1:0] start_back;
  logic [COORD_W-1:0] last_count;
  logic [COORD_W-1:0] count_inc;
  axis_phase_t        phase_next;

  // Segment boundaries as absolute counts along the axis.
  assign start_front = len_active;
  assign start_sync  = len_active + len_front;
  assign start_back  = start_sync + len_sync;
  assign last_count  = start_back + len_back - 1'b1;
  assign count_inc   = count + 1'b1;

  // wrap marks the final count of the axis; the counter returns to 0 on the
  // next step. Exposed unqualified so the vertical axis can AND it with its
  // own step condition.
  assign wrap = (count == last_count);

  // Position counter: advances on step, returns to 0 after the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count_inc;
    end
  end

  // Phase state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= ACTIVE;
    end else begin
      phase <= phase_next;
    end
  end

  // Next phase: move on when the incremented count reaches the next
  // boundary; wrap always lands in ACTIVE.
  always_comb begin
    phase_next = phase;
    if (step) begin
      if (wrap) begin
        phase_next = ACTIVE;
      end else begin
        case (phase)
          ACTIVE:  if (count_inc == start_front) phase_next = FRONT;
          FRONT:   if (count_inc == start_sync)  phase_next = SYNC;
          SYNC:    if (count_inc == start_back)  phase_next = BACK;
          default: phase_next = phase;
        endcase
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinates, display-active flag,
// sync pulses and line/frame start strobes, all registered together so
// every output carries the same one-pix_en latency from the counters.
// Optional feature macro: VGA_TIMING_FRAME_CTR_EN builds a 10-bit frame
// counter stepped at the start of vertical blanking; otherwise frame_ctr
// is tied to 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_active,
  output logic               h_sync,
  output logic               v_sync,
  output logic               line_start,
  output logic               frame_start,
  output logic [COORD_W-1:0] frame_ctr
);

  logic [COORD_W-1:0] h_count;
  logic [COORD_W-1:0] v_count;
  axis_phase_t        h_phase;
  axis_phase_t        v_phase;
  logic               h_wrap;
  logic               v_step;
  logic               unused_v_wrap;

  // The vertical axis moves one line each time the horizontal axis wraps.
  assign v_step = pix_en & h_wrap;

  vga_axis_counter u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .step       (pix_en),
    .len_active (COORD_W'(H_ACTIVE)),
    .len_front  (COORD_W'(H_FRONT)),
    .len_sync   (COORD_W'(H_SYNC)),
    .len_back   (COORD_W'(H_BACK)),
    .count      (h_count),
    .phase      (h_phase),
    .wrap       (h_wrap)
  );

  vga_axis_counter u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .step       (v_step),
    .len_active (COORD_W'(V_ACTIVE)),
    .len_front  (COORD_W'(V_FRONT)),
    .len_sync   (COORD_W'(V_SYNC)),
    .len_back   (COORD_W'(V_BACK)),
    .count      (v_count),
    .phase      (v_phase),
    .wrap       (unused_v_wrap)
  );

  // Output registers: capture the decode of the counters as they stand
  // before this pix_en edge, so all outputs describe the same pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x            <= '0;
      y            <= '0;
      frame_active <= 1'b0;
      h_sync       <= ~H_SYNC_POL;
      v_sync       <= ~V_SYNC_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else if (pix_en) begin
      x            <= h_count;
      y            <= v_count;
      frame_active <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
      h_sync       <= sync_level(h_phase == SYNC, H_SYNC_POL);
      v_sync       <= sync_level(v_phase == SYNC, V_SYNC_POL);
      line_start   <= (h_count == '0);
      frame_start  <= (h_count == '0) && (v_count == '0);
    end
  end

`ifdef VGA_TIMING_FRAME_CTR_EN
  // Frame counter: steps on the edge that loads the first blanking line
  // (x=0, y=V_ACTIVE); wraps naturally at 2^COORD_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_ctr <= '0;
    end else if (pix_en && (h_count == '0) && (v_count == COORD_W'(V_ACTIVE))) begin
      frame_ctr <= frame_ctr + 1'b1;
    end
  end
`else
  assign frame_ctr = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Two instances share clock, reset
// and pix_en: one with the default 640x480 timing (horizontal detail) and a
// shrunken one with inverted sync polarity so whole frames, vertical sync
// and the frame counter fit in a short run. Expected outputs come from an
// arithmetic model of the raster indexed by the number of pix_en edges.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_CTR_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // Shrunken timing for the second instance.
  localparam int SHA = 20, SHF = 3, SHS = 5, SHB = 4;   // H_TOTAL 32
  localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;   // V_TOTAL 19

  localparam int W = 35;

  logic clk;
  logic rst;
  logic pix_en;

  logic [9:0] xd, yd, fcd, xs, ys, fcs;
  logic       fad, hsd, vsd, lsd, fsd;
  logic       fas, hss, vss, lss, fss;

  vga_timing_gen dut_d (
    .clk (clk), .rst (rst), .pix_en (pix_en),
    .x (xd), .y (yd), .frame_active (fad), .h_sync (hsd), .v_sync (vsd),
    .line_start (lsd), .frame_start (fsd), .frame_ctr (fcd)
  );

  vga_timing_gen #(
    .H_ACTIVE (SHA), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
    .V_ACTIVE (SVA), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
    .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b1)
  ) dut_s (
    .clk (clk), .rst (rst), .pix_en (pix_en),
    .x (xs), .y (ys), .frame_active (fas), .h_sync (hss), .v_sync (vss),
    .line_start (lss), .frame_start (fss), .frame_ctr (fcs)
  );

  logic [W-1:0] act_d, act_s;
  assign act_d = {xd, yd, fad, hsd, vsd, lsd, fsd, fcd};
  assign act_s = {xs, ys, fas, hss, vss, lss, fss, fcs};

  int errors = 0;
  int checks = 0;
  int k = 0;                    // pix_en edges since reset release
  logic [W-1:0] exp_q_d[$];
  logic [W-1:0] exp_q_s[$];
  logic [W-1:0] cur_d, cur_s;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs after k pix_en edges: the pixel loaded last is number
  // k-1 in raster order.
  function automatic logic [W-1:0] model(input int kk, input int ha, input int hf,
                                         input int hs, input int hb, input int va,
                                         input int vf, input int vs, input int vb,
                                         input bit hp, input bit vp);
    int ht, vt, p, xx, yy, fc;
    logic fa, hsa, vsa;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (kk == 0) return {10'd0, 10'd0, 1'b0, ~hp, ~vp, 1'b0, 1'b0, 10'd0};
    p   = kk - 1;
    xx  = p % ht;
    yy  = (p / ht) % vt;
    fa  = (xx < ha) && (yy < va);
    hsa = (xx >= ha + hf) && (xx < ha + hf + hs);
    vsa = (yy >= va + vf) && (yy < va + vf + vs);
    fc  = 0;
    if (FC_EN && p >= va * ht) fc = ((p - va * ht) / (ht * vt) + 1) % 1024;
    return {10'(xx), 10'(yy), fa, (hsa ? hp : ~hp), (vsa ? vp : ~vp),
            (xx == 0), (xx == 0 && yy == 0), 10'(fc)};
  endfunction

  // Model: count enabled edges and queue the expected output vectors.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0;
      exp_q_d.delete();
      exp_q_s.delete();
      exp_q_d.push_back(model(0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
      exp_q_s.push_back(model(0, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 1'b1));
    end else if (pix_en) begin
      k = k + 1;
      exp_q_d.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
      exp_q_s.push_back(model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 1'b1));
    end
  end

  task automatic check_lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
    end
  endtask

  // Compare: every cycle, DUT outputs against the latest model vector,
  // plus hand-computed literal points that pin the model.
  always @(negedge clk) begin
    while (exp_q_d.size() > 0) cur_d = exp_q_d.pop_front();
    while (exp_q_s.size() > 0) cur_s = exp_q_s.pop_front();
    check_lit("dflt_vec", act_d, cur_d);
    check_lit("small_vec", act_s, cur_s);
    if (!rst) begin
      case (k)
        1:   check_lit("first_edge", {xd, yd, fad, lsd, fsd}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
        640: check_lit("x639_active", {xd, fad}, {10'd639, 1'b1});
        641: check_lit("x640_blank", {xd, fad}, {10'd640, 1'b0});
        656: check_lit("x655_nosync", {xd, hsd}, {10'd655, 1'b1});
        657: check_lit("x656_sync", {xd, hsd}, {10'd656, 1'b0});
        752: check_lit("x751_sync", {xd, hsd}, {10'd751, 1'b0});
        753: check_lit("x752_nosync", {xd, hsd}, {10'd752, 1'b1});
        800: check_lit("x799", {xd, yd, lsd}, {10'd799, 10'd0, 1'b0});
        801: check_lit("wrap_line1", {xd, yd, lsd, fsd}, {10'd0, 10'd1, 1'b1, 1'b0});
        default: ;
      endcase
      case (k)
        385:  check_lit("s_blank_fc1", {xs, ys, fas, fcs}, {10'd0, 10'd12, 1'b0, (FC_EN ? 10'd1 : 10'd0)});
        471:  check_lit("s_vsync_on", {ys, vss}, {10'd14, 1'b1});
        537:  check_lit("s_vsync_off", {ys, vss}, {10'd16, 1'b0});
        608:  check_lit("s_last_pix", {xs, ys}, {10'd31, 10'd18});
        609:  check_lit("s_frame_wrap", {xs, ys, fss}, {10'd0, 10'd0, 1'b1});
        1601: check_lit("s_fc3", fcs, (FC_EN ? 10'd3 : 10'd0));
        default: ;
      endcase
    end
  end

  // Driver: change inputs just after the active edge.
  task automatic drive_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      case (mode)
        0:       pix_en = 1'b1;
        1:       pix_en = (i % 2 == 0);
        default: pix_en = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  // Stimulus sequence and final report.
  initial begin
    rst = 1'b1;
    pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_lit("rst_vals_d", act_d, {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0});
    check_lit("rst_vals_s", act_s, {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0});
    rst = 1'b0;
    drive_cycles(2000, 0);   // continuous enable through two lines
    drive_cycles(1000, 1);   // alternating enable
    drive_cycles(4000, 2);   // random gaps
    // Asynchronous reset mid-line: outputs must clear before any clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_lit("rst_async_d", act_d, {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0});
    check_lit("rst_async_s", act_s, {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0});
    @(posedge clk);
    #1 rst = 1'b0;
    pix_en = 1'b0;
    drive_cycles(3000, 0);   // three full small frames back to back
    drive_cycles(3000, 2);
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
